// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package regfile_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam int XLEN_D  = 32;
  localparam int NREG_D  = 32;
  localparam int NREAD_D = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination busy, writeback retires it.
// Built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG  = NREG_D,
  parameter  int NREAD = NREAD_D,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy
);

  logic [NREG-1:0]  busy, busy_next;
  logic [NREAD-1:0] busy_rd;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy;
    if (run && we)        busy_next[wr_addr]  = 1'b0;
    if (run && iss_valid) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    assign busy_rd[p] = run & busy_next[rd_addr[p*AW +: AW]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      rd_busy <= '0;
    end else begin
      busy    <= busy_next;
      rd_busy <= busy_rd;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NREAD registered read ports with write bypass,
// one write port, post-reset clear sequence; busy scoreboard under REGFILE_SCOREBOARD_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_D,
  parameter  int NREG  = NREG_D,
  parameter  int NREAD = NREAD_D,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr
);

  state_t                       state, state_next;
  logic [AW-1:0]                clr_idx;
  logic                         run;
  logic [XLEN-1:0]              regs [NREG];
  logic [NREAD-1:0][XLEN-1:0]   rd_next;

  assign run = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_idx == AW'(NREG-1)) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      if (!run) clr_idx <= clr_idx + 1'b1;
      ready <= (state_next == ST_RUN);
    end
  end

  // No reset on the array; CLEAR walks every entry to zero instead.
  always_ff @(posedge clk) begin
    if (!run)                      regs[clr_idx] <= '0;
    else if (we && wr_addr != '0)  regs[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];
    assign rd_next[p] = (!run || addr == '0)      ? '0      :
                        (we && wr_addr == addr)    ? wr_data :
                                                     regs[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_next;
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(.NREG(NREG), .NREAD(NREAD)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .we        (we),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr};
  assign rd_busy    = '0;
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default 32x32, 2 read ports).
module tb_regfile_multiport;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;

  int checks = 0;
  int errors = 0;

  regfile_multiport dut (
    .clk(clk), .rst(rst), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    #2;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b want 0", rd_busy); end
    step(); step();
    rst = 1'b0;
    rd_addr = {5'd4, 5'd5};
    step(); step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL clear_rd_data got %h want 0", rd_data); end
    wait_ready(n);
    n += 2;
    checks++; if (n !== 32) begin errors++; $display("FAIL clear_edges got %0d want 32", n); end
  endtask

  task automatic test_clear();
    int n;
    idle();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    step();
    idle(); rd_addr = {5'd0, 5'd5};
    step();
    checks++; if (rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL prewrite_r5 got %h want 00001234", rd_data[31:0]); end
    // async reset mid-RUN, away from any edge
    #2; rst = 1'b1; #1;
    checks++; if (ready !== 1'b0 || rd_data !== 64'h0) begin errors++; $display("FAIL async_drop ready %b data %h want 0/0", ready, rd_data); end
    step();
    rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL reclear_edges got %0d want 32", n); end
    rd_addr = {5'd5, 5'd5};
    step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL cleared_r5 got %h want 0", rd_data); end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    step();
    idle(); rd_addr = {5'd3, 5'd0};
    step();
    checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p1 got %h want deadbeef", rd_data[63:32]); end
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL wr_rd_p0_r0 got %h want 0", rd_data[31:0]); end
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd3, 5'd7};
    step();
    checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_we1 got %h want a5a5a5a5", rd_data[31:0]); end
    we = 1'b0; wr_addr = 5'd7; wr_data = 32'h11111111; rd_addr = {5'd3, 5'd7};
    step();
    checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_we0 got %h want a5a5a5a5", rd_data[31:0]); end
    checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_port got %h want deadbeef", rd_data[63:32]); end
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A5A5A5A; rd_addr = {5'd7, 5'd7};
    step();
    checks++; if (rd_data !== {2{32'h5A5A5A5A}}) begin errors++; $display("FAIL bypass_both_ports got %h want 5a5a5a5a5a5a5a5a", rd_data); end
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
    step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL r0_bypass got %h want 0", rd_data); end
    idle(); rd_addr = {5'd0, 5'd0};
    step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL r0_read got %h want 0", rd_data); end
  endtask

  task automatic test_back_to_back();
    idle();
    we = 1'b1; wr_addr = 5'd1; wr_data = 32'h00000011;
    step();
    wr_addr = 5'd2; wr_data = 32'h00000022; rd_addr = {5'd2, 5'd1};
    step();
    checks++; if (rd_data !== {32'h22, 32'h11}) begin errors++; $display("FAIL b2b_1 got %h want %h", rd_data, {32'h22, 32'h11}); end
    wr_addr = 5'd1; wr_data = 32'h00000033; rd_addr = {5'd2, 5'd1};
    step();
    checks++; if (rd_data !== {32'h22, 32'h33}) begin errors++; $display("FAIL b2b_2 got %h want %h", rd_data, {32'h22, 32'h33}); end
    idle(); rd_addr = {5'd31, 5'd1};
    step();
    checks++; if (rd_data !== {32'h0, 32'h33}) begin errors++; $display("FAIL b2b_3 got %h want %h", rd_data, {32'h0, 32'h33}); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_addr = 5'd9; rd_addr = {5'd3, 5'd9};
    step();
`ifdef REGFILE_SCOREBOARD_EN
    checks++; if (rd_busy !== 2'b01) begin errors++; $display("FAIL sb_issue got %b want 01", rd_busy); end
    iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
    step();
    checks++; if (rd_busy !== 2'b01) begin errors++; $display("FAIL sb_set_wins got %b want 01", rd_busy); end
    idle(); rd_addr = {5'd9, 5'd9};
    step();
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_hold got %b want 11", rd_busy); end
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    step();
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_retire got %b want 00", rd_busy); end
    idle(); iss_valid = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    step();
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_r0 got %b want 00", rd_busy); end
`else
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_off got %b want 00", rd_busy); end
`endif
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midclear_ready got %b want 0", ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL midclear_edges got %0d want 32", n); end
    rd_addr = {5'd1, 5'd3};
    step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL midclear_zeroed got %h want 0", rd_data); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_clear();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_scoreboard();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised integer register file for the CPU core. It replaces the fixed 2-read/1-write, 32x32 design with configurable width, depth and read-port count, write-enable-qualified bypass, a hardware clear sequence after reset, and an optional busy scoreboard for pipelined hazard detection. It sits between decode (read addresses, issue marking) and writeback (write port).

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 2; AW = $clog2(NREG).
- NREAD, 2, number of read ports, at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  high once the clear sequence has completed.
- rd_addr  in  NREAD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NREAD*XLEN  packed registered read data.
- rd_busy  out  NREAD  registered busy flag per read port; scoreboard build only, else tied 0.
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- iss_valid  in  1  marks iss_addr busy (scoreboard build only).
- iss_addr  in  AW  destination register of the issuing instruction.

## Operation
- The FSM has two states:
  - CLEAR: entered on rst. clr_idx counts 0..NREG-1, and the block writes regs[clr_idx]=0 each cycle. At clr_idx==NREG-1 the FSM moves to RUN and ready is set.
  - RUN: normal operation. The FSM stays here until rst.
- Reset values:
  - ready=0, rd_data=0, rd_busy=0, all busy bits 0, clr_idx=0, state CLEAR.
  - The array itself has no reset; it is zeroed by CLEAR.
- During CLEAR:
  - we and iss_valid are ignored.
  - rd_data and rd_busy update to 0 each cycle.
- Read, per port p, in RUN: rd_data[p] <= 0 if addr==0; else wr_data if we and wr_addr==addr; else regs[addr].
- Bypass requires we=1. A matching wr_addr with we=0 returns array contents.
- Write: when we and wr_addr!=0, regs[wr_addr] <= wr_data. Writes to register 0 are discarded.
- Scoreboard, in RUN:
  - iss_valid sets busy[iss_addr].
  - we clears busy[wr_addr].
  - When both target the same address in the same cycle, set wins: a new producer supersedes the retiring one.
  - Register 0 is never busy.
  - rd_busy[p] <= busy_next[rd_addr[p]], the post-update value.
- Multiple read ports may present the same address; each returns identical data.

## Timing
- Read latency is 1 cycle: an address presented at edge N produces data valid after edge N+1.
- A write at edge N is visible to a read presented at edge N through the bypass, and through the array thereafter.
- ready rises at the NREG-th rising edge after rst deasserts, and stays high until the next rst.
- rst asserted mid-CLEAR or mid-RUN:
  - Outputs drop immediately.
  - The sequence restarts at clr_idx=0.
  - In-flight writes are lost.
- Busy state is 0 after every reset.

## Configuration
- REGFILE_SCOREBOARD_EN defined:
  - The busy bit vector, iss_valid/iss_addr handling and rd_busy logic are built.
- REGFILE_SCOREBOARD_EN undefined:
  - No busy storage is built.
  - rd_busy is constant 0.
  - iss_valid and iss_addr are ignored.
  - Read and write behaviour is identical to the scoreboard build.

## Structure
- Package regfile_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_RUN);
  - default parameter constants XLEN_D=32, NREG_D=32, NREAD_D=2.
- Sub-module regfile_scoreboard holds:
  - the NREG busy bits with their set/clear/priority logic;
  - NREAD registered lookups.
- regfile_scoreboard is instantiated only under REGFILE_SCOREBOARD_EN.

## Test plan
- Clear: pulse rst, hold we=0.
  - ready=0 for exactly 32 edges, then 1.
  - Reading r5 returns 0 even after a pre-reset write of 0x1234.
- Write/read: write r3=0xDEADBEEF, then read r3 on port 1 the next cycle.
  - rd_data port 1 = 0xDEADBEEF one cycle later.
  - Port 0 reading r0 = 0.
- Bypass: same cycle, we=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr port 0=7.
  - Next cycle rd_data = 0xA5A5A5A5.
  - Repeat with we=0: old r7 value is returned.
- Zero register: write r0=0xFFFFFFFF, then read r0 on all ports.
  - Result is 0.
- Scoreboard (REGFILE_SCOREBOARD_EN):
  - Issue r9: rd_busy=1 for r9.
  - Simultaneous iss r9 and write r9: r9 stays busy.
  - Write r9 alone: rd_busy=0.
- Reset mid-clear: assert rst at clr_idx=10.
  - ready stays 0 for a full 32 edges after release.
